// File: rtl/caesar_mem_arb_pkg.sv
// Shared definitions for the Caesar memory arbiter.
//   arb_state_e : retention sequencer states
//   req_id_e    : requester identity, also used as the round-robin pointer
//   DEFAULT_*   : default idle / wake-up cycle counts
package caesar_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_RETENTIVE = 2'd1,
    ST_WAKEUP    = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_BUS = 1'b0,
    REQ_ENG = 1'b1
  } req_id_e;

  localparam int unsigned DEFAULT_IDLE_CYCLES = 64;
  localparam int unsigned DEFAULT_WAKE_CYCLES = 2;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned BE_W                = 4;

endpackage

// File: rtl/caesar_rr_arb2.sv
// Two-input round-robin arbiter with a combinational grant.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   en_i                   : grants are only issued while high
//   bus_req_i, eng_req_i   : requests
//   bus_gnt_o, eng_gnt_o   : one-hot (or zero) grant, same cycle as request
//   last_o                 : requester granted most recently
// The pointer records the last winner; on a tie the other requester wins.
// Reset points at the engine so the bus wins the first tie.
module caesar_rr_arb2
  import caesar_mem_arb_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  logic    bus_req_i,
  input  logic    eng_req_i,
  output logic    bus_gnt_o,
  output logic    eng_gnt_o,
  output req_id_e last_o
);

  req_id_e last_q;

  always_comb begin
    bus_gnt_o = 1'b0;
    eng_gnt_o = 1'b0;
    if (en_i) begin
      if (bus_req_i && eng_req_i) begin
        if (last_q == REQ_BUS) eng_gnt_o = 1'b1;
        else                   bus_gnt_o = 1'b1;
      end else begin
        bus_gnt_o = bus_req_i;
        eng_gnt_o = eng_req_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_ENG;
    end else if (bus_gnt_o) begin
      last_q <= REQ_BUS;
    end else if (eng_gnt_o) begin
      last_q <= REQ_ENG;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/caesar_mem_arbiter.sv
// Shares one 32-bit, byte-enabled, 1-cycle-latency Caesar SRAM bank between
// the system bus port and the Caesar compute engine, and sequences the
// bank's retention control.
//
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   bus_* / eng_*                 : OBI-style requester ports
//                                   (req, we, addr, wdata, be -> gnt, rvalid, rdata)
//   ret_en_i                      : auto-retention enable
//   mem_req/we/addr/wdata/be_o    : bank request, driven from the winner
//   mem_set_retentive_no          : bank retention control, active-low
//   mem_rdata_i                   : bank read data, one cycle after mem_req_o
//   retentive_o                   : high while the bank is held in retention
//
// Handshake: a requester raises req with its command and holds it stable
// until gnt is seen high in the same cycle; the transfer happens on that
// cycle. Exactly one cycle later rvalid pulses on that port (reads and
// writes alike) with rdata valid for reads. rvalid cannot be back-pressured.
//
// Retention: after IDLE_CYCLES idle ACTIVE cycles with ret_en_i set, the bank
// is put into retention. Any request (or dropping ret_en_i) releases it, and
// grants resume after WAKE_CYCLES cycles of WAKEUP. Requests stay pending
// (gnt low) across RETENTIVE and WAKEUP.
module caesar_mem_arbiter
  import caesar_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
  localparam int unsigned AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [AddrWidth-1:0] bus_addr_i,
  input  logic [DATA_W-1:0]    bus_wdata_i,
  input  logic [BE_W-1:0]      bus_be_i,
  output logic                 bus_gnt_o,
  output logic                 bus_rvalid_o,
  output logic [DATA_W-1:0]    bus_rdata_o,
  input  logic                 eng_req_i,
  input  logic                 eng_we_i,
  input  logic [AddrWidth-1:0] eng_addr_i,
  input  logic [DATA_W-1:0]    eng_wdata_i,
  input  logic [BE_W-1:0]      eng_be_i,
  output logic                 eng_gnt_o,
  output logic                 eng_rvalid_o,
  output logic [DATA_W-1:0]    eng_rdata_o,
  input  logic                 ret_en_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  output logic [BE_W-1:0]      mem_be_o,
  output logic                 mem_set_retentive_no,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 retentive_o
);

  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IdleW-1:0] IDLE_MAX  = IdleW'(IDLE_CYCLES);
  localparam logic [WakeW-1:0] WAKE_LAST = WakeW'(WAKE_CYCLES - 1);

  arb_state_e       state_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic [WakeW-1:0] wake_cnt_q;
  logic             rsp_valid_q;
  req_id_e          rsp_owner_q;
  req_id_e          rr_last;
  logic             any_req;

  assign any_req = bus_req_i | eng_req_i;

  // ---------------------------------------------------------------------
  // Arbitration: grants only while the bank is fully awake.
  // ---------------------------------------------------------------------
  caesar_rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (state_q == ST_ACTIVE),
    .bus_req_i (bus_req_i),
    .eng_req_i (eng_req_i),
    .bus_gnt_o (bus_gnt_o),
    .eng_gnt_o (eng_gnt_o),
    .last_o    (rr_last)
  );

  assign mem_req_o = bus_gnt_o | eng_gnt_o;

  // Idle bank sees an all-zero command so downstream probes stay quiet.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (bus_gnt_o) begin
      mem_we_o    = bus_we_i;
      mem_addr_o  = bus_addr_i;
      mem_wdata_o = bus_wdata_i;
      mem_be_o    = bus_be_i;
    end else if (eng_gnt_o) begin
      mem_we_o    = eng_we_i;
      mem_addr_o  = eng_addr_i;
      mem_wdata_o = eng_wdata_i;
      mem_be_o    = eng_be_i;
    end
  end

  // ---------------------------------------------------------------------
  // Response pipe: matches the bank's single-cycle read latency.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= REQ_BUS;
    end else begin
      rsp_valid_q <= mem_req_o;
      if (mem_req_o) rsp_owner_q <= eng_gnt_o ? REQ_ENG : REQ_BUS;
    end
  end

  assign bus_rvalid_o = rsp_valid_q && (rsp_owner_q == REQ_BUS);
  assign eng_rvalid_o = rsp_valid_q && (rsp_owner_q == REQ_ENG);
  assign bus_rdata_o  = bus_rvalid_o ? mem_rdata_i : '0;
  assign eng_rdata_o  = eng_rvalid_o ? mem_rdata_i : '0;

  // ---------------------------------------------------------------------
  // Retention sequencer.
  // A request on the threshold cycle takes priority over retention entry,
  // so that cycle is granted and the counter restarts.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (any_req) begin
            idle_cnt_q <= '0;
          end else if ((idle_cnt_q == IDLE_MAX) && ret_en_i) begin
            state_q    <= ST_RETENTIVE;
            idle_cnt_q <= '0;
          end else if (!rsp_valid_q && (idle_cnt_q != IDLE_MAX)) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        ST_RETENTIVE: begin
          idle_cnt_q <= '0;
          if (any_req || !ret_en_i) begin
            state_q    <= ST_WAKEUP;
            wake_cnt_q <= '0;
          end
        end
        ST_WAKEUP: begin
          // ret_en_i is ignored here: once started, wake-up always completes.
          idle_cnt_q <= '0;
          if (wake_cnt_q == WAKE_LAST) begin
            state_q    <= ST_ACTIVE;
            wake_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_ACTIVE;
          idle_cnt_q <= '0;
          wake_cnt_q <= '0;
        end
      endcase
    end
  end

  assign retentive_o          = (state_q == ST_RETENTIVE);
  assign mem_set_retentive_no = (state_q != ST_RETENTIVE);

  // The pointer is observable for checkers; it has no other consumer here.
  logic unused_ok;
  assign unused_ok = ^rr_last;

endmodule

// File: tb/tb_caesar_mem_arbiter.sv
module tb_caesar_mem_arbiter;

  localparam int AW = 10;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic          bus_req_i = 0, bus_we_i = 0;
  logic [AW-1:0] bus_addr_i = '0;
  logic [31:0]   bus_wdata_i = '0;
  logic [3:0]    bus_be_i = '0;
  logic          bus_gnt_o, bus_rvalid_o;
  logic [31:0]   bus_rdata_o;
  logic          eng_req_i = 0, eng_we_i = 0;
  logic [AW-1:0] eng_addr_i = '0;
  logic [31:0]   eng_wdata_i = '0;
  logic [3:0]    eng_be_i = '0;
  logic          eng_gnt_o, eng_rvalid_o;
  logic [31:0]   eng_rdata_o;
  logic          ret_en_i = 0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_set_retentive_no;
  logic [31:0]   mem_rdata_i = '0;
  logic          retentive_o;

  caesar_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .bus_be_i(bus_be_i), .bus_gnt_o(bus_gnt_o),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
    .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i),
    .eng_wdata_i(eng_wdata_i), .eng_be_i(eng_be_i), .eng_gnt_o(eng_gnt_o),
    .eng_rvalid_o(eng_rvalid_o), .eng_rdata_o(eng_rdata_o),
    .ret_en_i(ret_en_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_set_retentive_no(mem_set_retentive_no),
    .mem_rdata_i(mem_rdata_i), .retentive_o(retentive_o)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];   // expected response owner: 0 = bus, 1 = eng

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // inputs change on the falling edge, outputs sampled 1ns later
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic sample();
    #1;
  endtask

  logic       exp_bus;
  logic [0:0] owner;
  logic       saw_ret;

  initial begin
    // ---------------- reset state ----------------
    mem_rdata_i = 32'h1234_5678;
    next_cycle(); sample();
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_bus_gnt", 32'(bus_gnt_o), 0);
    chk("rst_rvalid", 32'({bus_rvalid_o, eng_rvalid_o}), 0);
    chk("rst_bus_rdata", bus_rdata_o, 0);
    chk("rst_ret_no", 32'(mem_set_retentive_no), 1);
    chk("rst_retentive", 32'(retentive_o), 0);
    next_cycle(); rst_i = 0;

    // ---------------- bus read, engine idle ----------------
    next_cycle();
    bus_req_i = 1; bus_we_i = 0; bus_addr_i = 10'h010; bus_be_i = 4'hF;
    sample();
    chk("rd_bus_gnt", 32'(bus_gnt_o), 1);
    chk("rd_eng_gnt", 32'(eng_gnt_o), 0);
    chk("rd_mem_req", 32'(mem_req_o), 1);
    chk("rd_mem_addr", 32'(mem_addr_o), 32'h010);
    chk("rd_mem_we", 32'(mem_we_o), 0);
    next_cycle();
    bus_req_i = 0; mem_rdata_i = 32'hCAFE_0010;
    sample();
    chk("rd_bus_rvalid", 32'(bus_rvalid_o), 1);
    chk("rd_bus_rdata", bus_rdata_o, 32'hCAFE_0010);
    chk("rd_eng_rvalid", 32'(eng_rvalid_o), 0);
    chk("rd_eng_rdata", eng_rdata_o, 0);
    chk("rd_idle_addr", 32'(mem_addr_o), 0);

    // ---------------- engine write ----------------
    next_cycle();
    eng_req_i = 1; eng_we_i = 1; eng_addr_i = 10'h3FF;
    eng_wdata_i = 32'hDEAD_BEEF; eng_be_i = 4'b0101;
    sample();
    chk("wr_eng_gnt", 32'(eng_gnt_o), 1);
    chk("wr_bus_gnt", 32'(bus_gnt_o), 0);
    chk("wr_mem_we", 32'(mem_we_o), 1);
    chk("wr_mem_be", 32'(mem_be_o), 32'h5);
    chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("wr_mem_addr", 32'(mem_addr_o), 32'h3FF);
    next_cycle();
    eng_req_i = 0; eng_we_i = 0;
    sample();
    chk("wr_eng_rvalid", 32'(eng_rvalid_o), 1);
    chk("wr_bus_rvalid", 32'(bus_rvalid_o), 0);

    // ---------------- both requesting: alternate BUS,ENG,... ----------------
    next_cycle();
    bus_req_i = 1; bus_addr_i = 10'h001; eng_req_i = 1; eng_addr_i = 10'h002;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        next_cycle();
        mem_rdata_i = 32'h0000_0100 + 32'(i);
      end
      sample();
      exp_bus = (i % 2 == 0);
      chk("alt_bus_gnt", 32'(bus_gnt_o), 32'(exp_bus));
      chk("alt_eng_gnt", 32'(eng_gnt_o), 32'(!exp_bus));
      chk("alt_mem_req", 32'(mem_req_o), 1);
      chk("alt_mem_addr", 32'(mem_addr_o), exp_bus ? 32'h001 : 32'h002);
      if (i > 0) begin
        owner = exp_q.pop_front();
        chk("alt_bus_rvalid", 32'(bus_rvalid_o), 32'(owner == 1'b0));
        chk("alt_eng_rvalid", 32'(eng_rvalid_o), 32'(owner == 1'b1));
        chk("alt_rdata", owner ? eng_rdata_o : bus_rdata_o, 32'h0000_0100 + 32'(i));
      end
      exp_q.push_back(exp_bus ? 1'b0 : 1'b1);
    end
    next_cycle();
    bus_req_i = 0; eng_req_i = 0; mem_rdata_i = 32'h0000_0106;
    sample();
    owner = exp_q.pop_front();
    chk("alt_last_owner", 32'(owner), 1);
    chk("alt_last_eng_rvalid", 32'(eng_rvalid_o), 1);
    chk("alt_last_eng_rdata", eng_rdata_o, 32'h0000_0106);
    chk("alt_last_mem_req", 32'(mem_req_o), 0);

    // ---------------- auto-retention entry and wake-up ----------------
    next_cycle();                                   // cycle C: clears idle count
    bus_req_i = 1; bus_addr_i = 10'h000;
    sample();
    chk("ret_pre_gnt", 32'(bus_gnt_o), 1);
    next_cycle();                                   // C+1: response pending
    bus_req_i = 0; ret_en_i = 1;
    sample();
    saw_ret = 0;
    for (int j = 2; j <= 66; j++) begin             // C+2..C+66 still ACTIVE
      next_cycle(); sample();
      if (retentive_o) saw_ret = 1;
    end
    chk("ret_not_early", 32'(saw_ret), 0);
    next_cycle(); sample();                         // C+67
    chk("ret_entered", 32'(retentive_o), 1);
    chk("ret_no_low", 32'(mem_set_retentive_no), 0);
    next_cycle();                                   // request during retention
    bus_req_i = 1; bus_addr_i = 10'h020;
    sample();
    chk("ret_req_gnt", 32'(bus_gnt_o), 0);
    chk("ret_req_mem_req", 32'(mem_req_o), 0);
    next_cycle();                                   // WAKEUP 0
    ret_en_i = 0;
    sample();
    chk("wake0_ret_no", 32'(mem_set_retentive_no), 1);
    chk("wake0_retentive", 32'(retentive_o), 0);
    chk("wake0_gnt", 32'(bus_gnt_o), 0);
    next_cycle();                                   // WAKEUP 1
    ret_en_i = 1;
    sample();
    chk("wake1_gnt", 32'(bus_gnt_o), 0);
    chk("wake1_mem_req", 32'(mem_req_o), 0);
    next_cycle(); sample();                         // first ACTIVE cycle
    chk("wake_act_gnt", 32'(bus_gnt_o), 1);
    chk("wake_act_addr", 32'(mem_addr_o), 32'h020);
    next_cycle();
    bus_req_i = 0; ret_en_i = 0; mem_rdata_i = 32'h5A5A_0020;
    sample();
    chk("wake_rvalid", 32'(bus_rvalid_o), 1);
    chk("wake_rdata", bus_rdata_o, 32'h5A5A_0020);

    // ---------------- retention disabled: never enters ----------------
    saw_ret = 0;
    for (int j = 0; j < 200; j++) begin
      next_cycle(); sample();
      if (retentive_o || !mem_set_retentive_no) saw_ret = 1;
    end
    chk("noret_200", 32'(saw_ret), 0);

    // ---------------- request on the threshold cycle ----------------
    next_cycle();
    ret_en_i = 1; eng_req_i = 1; eng_we_i = 1; eng_addr_i = 10'h055;
    eng_wdata_i = 32'h0123_4567; eng_be_i = 4'hF;
    sample();
    chk("thr_eng_gnt", 32'(eng_gnt_o), 1);
    chk("thr_mem_wdata", mem_wdata_o, 32'h0123_4567);
    next_cycle();
    eng_req_i = 0; eng_we_i = 0;
    sample();
    chk("thr_eng_rvalid", 32'(eng_rvalid_o), 1);
    chk("thr_no_ret", 32'(retentive_o), 0);
    chk("thr_ret_no", 32'(mem_set_retentive_no), 1);
    next_cycle();
    ret_en_i = 0;
    sample();
    chk("thr_still_active", 32'(retentive_o), 0);

    // ---------------- reset mid-transfer ----------------
    next_cycle();
    bus_req_i = 1; eng_req_i = 1; bus_addr_i = 10'h0AA; eng_addr_i = 10'h0BB;
    sample();
    chk("mid_bus_gnt", 32'(bus_gnt_o), 1);
    next_cycle();
    rst_i = 1; bus_req_i = 0; eng_req_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
    sample();
    chk("mid_bus_rvalid", 32'(bus_rvalid_o), 0);
    chk("mid_eng_rvalid", 32'(eng_rvalid_o), 0);
    chk("mid_bus_rdata", bus_rdata_o, 0);
    chk("mid_mem_req", 32'(mem_req_o), 0);
    chk("mid_mem_addr", 32'(mem_addr_o), 0);
    chk("mid_mem_be", 32'(mem_be_o), 0);
    chk("mid_ret_no", 32'(mem_set_retentive_no), 1);
    chk("mid_retentive", 32'(retentive_o), 0);
    next_cycle();
    rst_i = 0;
    next_cycle();
    bus_req_i = 1; eng_req_i = 1;
    sample();
    chk("post_rst_tie_bus", 32'(bus_gnt_o), 1);
    chk("post_rst_tie_eng", 32'(eng_gnt_o), 0);
    chk("post_rst_addr", 32'(mem_addr_o), 32'h0AA);
    next_cycle(); sample();
    chk("post_rst_next_eng", 32'(eng_gnt_o), 1);
    chk("post_rst_bus_rvalid", 32'(bus_rvalid_o), 1);
    next_cycle();
    bus_req_i = 0; eng_req_i = 0;
    sample();
    chk("post_rst_eng_rvalid", 32'(eng_rvalid_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/caesar_mem_arbiter.md
Name: caesar_mem_arbiter

Overview:
- Shares one Caesar SRAM bank (the 32-bit, byte-enabled, 1-cycle read-latency bank macro wrapper) between two requesters: the system bus port and the Caesar compute engine.
- Fair round-robin arbitration with OBI-style req/gnt/rvalid handshakes toward both requesters.
- Also sequences the bank's retention control: enters retention after a programmable idle period and performs a timed wake-up before granting again.
- Sits between the Caesar bus adapter / engine and the bank SRAM wrapper.

Parameters:
- NUM_WORDS, 1024, words in the bank.
- IDLE_CYCLES, 64, consecutive idle ACTIVE cycles before entering retention (≥1).
- WAKE_CYCLES, 2, cycles retention must be released before the first grant (≥1).
- AddrWidth, localparam, (NUM_WORDS>1) ? $clog2(NUM_WORDS) : 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- bus_req_i / eng_req_i  in  1  request
- bus_we_i / eng_we_i  in  1  write enable
- bus_addr_i / eng_addr_i  in  AddrWidth  word address
- bus_wdata_i / eng_wdata_i  in  32  write data
- bus_be_i / eng_be_i  in  4  byte enables
- bus_gnt_o / eng_gnt_o  out  1  grant (combinational)
- bus_rvalid_o / eng_rvalid_o  out  1  response valid, 1 cycle after grant
- bus_rdata_o / eng_rdata_o  out  32  read data, valid with rvalid
- ret_en_i  in  1  auto-retention enable
- mem_req_o  out  1  bank request
- mem_we_o  out  1  bank write enable
- mem_addr_o  out  AddrWidth  bank address
- mem_wdata_o  out  32  bank write data
- mem_be_o  out  4  bank byte enables
- mem_set_retentive_no  out  1  bank retention, active-low
- mem_rdata_i  in  32  bank read data
- retentive_o  out  1  status: state == RETENTIVE

Behaviour:
- Reset (async, rst_i=1):
  - State ACTIVE; all outputs 0 except mem_set_retentive_no=1.
  - RR pointer last=ENG, so bus wins the first tie.
  - Idle/wake counters 0.
  - Any pending rvalid is dropped.
- FSM states: ACTIVE, RETENTIVE, WAKEUP.
- ACTIVE, arbitration:
  - Only one requester: it is granted in the same cycle.
  - Both requesting: the one not granted last wins; the pointer updates on every grant.
  - At most one grant per cycle.
  - mem_* driven combinationally from the winner; mem_req_o = any grant.
  - With no grant, mem_addr/wdata/be/we = 0.
- Response:
  - Registered owner flag + valid; rvalid_o asserted to the owner exactly 1 cycle after its grant, for reads and writes.
  - rdata_o = mem_rdata_i for the owner, 0 for the other port.
  - Back-to-back grants are allowed every cycle (full throughput).
- Idle counter (ACTIVE only):
  - Counts cycles with no req and no pending rvalid; cleared by any req.
  - Saturates at IDLE_CYCLES.
  - When count==IDLE_CYCLES and ret_en_i=1 → RETENTIVE; counter cleared.
- RETENTIVE:
  - mem_set_retentive_no=0, no grants, mem_req_o=0.
  - Any req or ret_en_i=0 → WAKEUP (wake counter cleared).
- WAKEUP:
  - mem_set_retentive_no=1, no grants.
  - Wake counter increments each cycle; on reaching WAKE_CYCLES-1 → ACTIVE.
  - Requests are held by the requester (gnt low) and are served from the first ACTIVE cycle.
- Request arriving in the same cycle the idle threshold is reached: the req clears the counter, so stay ACTIVE and grant.
- ret_en_i toggling in WAKEUP has no effect; wake-up completes.
- Counter widths: $clog2(param+1).

Decomposition:
- Package caesar_mem_arb_pkg:
  - state enum (ACTIVE, RETENTIVE, WAKEUP);
  - requester id enum (REQ_BUS, REQ_ENG);
  - default IDLE/WAKE constants.
- Natural sub-module: caesar_rr_arb2 (2-input round-robin, combinational grant + pointer register).
- The parent instantiates the arbiter, the FSM/counters and the response pipe, and connects to caesar_sram_wrapper at the top level.

Test Plan:
- Reset then bus read addr 0x010 with eng idle → bus_gnt_o=1 same cycle; mem_addr_o=0x010, mem_we_o=0; bus_rvalid_o=1 next cycle with rdata = mem_rdata_i; eng_rvalid_o=0.
- Both requesting continuously for 6 cycles → grants alternate BUS,ENG,BUS,ENG,BUS,ENG; rvalid follows the owner one cycle later; exactly one mem_req_o per cycle.
- Eng write wdata=0xDEADBEEF, be=0b0101 → mem_we_o=1, mem_be_o=0x5, mem_wdata_o=0xDEADBEEF; eng_rvalid_o=1 next cycle.
- ret_en_i=1, no traffic for IDLE_CYCLES (64) cycles → mem_set_retentive_no=0, retentive_o=1. Then bus_req_i=1 → retention released next cycle; gnt held low for WAKE_CYCLES=2 cycles; granted on the first ACTIVE cycle.
- ret_en_i=0 with 200 idle cycles → never enters retention. Request on the exact threshold cycle with ret_en_i=1 → granted; no retention entry.
- Assert rst_i mid-transfer (one cycle after grant) → rvalid suppressed, all outputs at reset values immediately, mem_set_retentive_no=1; the first tie after reset goes to bus.
